// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_NOP      = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_pc_sel.sv
// Next-fetch target mux and alignment handling.
// IF_ALIGN_CHECK_EN: flag misaligned targets instead of silently clearing bits [1:0].
module if_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic            jump_en,
  input  logic            expc_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] seq_pc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] raw_s;

  // Jump has priority over an EX-resolved branch.
  always_comb begin
    raw_s = seq_pc;
    if (jump_en) begin
      raw_s = jump_target;
    end else if (expc_en) begin
      raw_s = ex_target;
    end else begin
      raw_s = seq_pc;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  assign target     = raw_s;
  assign misaligned = (raw_s[1:0] != 2'b00);
`else
  assign target     = raw_s & ALIGN_MASK;
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC select, imem req/gnt/rvalid handshake, instr latch.
// IF_ALIGN_CHECK_EN enables the misaligned-target error path.
module instr_fetch
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PC_en,
  input  logic            Jump_en,
  input  logic            EXPC_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] ex_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc_out,
  output logic            fetch_done,
  output logic            fetch_busy,
  output logic            fetch_err
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  if_state_e       state_r, state_nxt_s;
  logic [XLEN-1:0] seq_pc_r, seq_pc_nxt_s;
  logic [XLEN-1:0] addr_nxt_s, pc_nxt_s, target_s;
  logic [31:0]     instr_nxt_s;
  logic            req_nxt_s, done_nxt_s, err_nxt_s, misaligned_s;

  if_pc_sel #(.XLEN(XLEN)) u_pc_sel (
    .jump_en     (Jump_en),
    .expc_en     (EXPC_en),
    .jump_target (jump_target),
    .ex_target   (ex_target),
    .seq_pc      (seq_pc_r),
    .target      (target_s),
    .misaligned  (misaligned_s)
  );

  // Next-state and next-output logic; imem_addr doubles as the held fetch address.
  always_comb begin
    state_nxt_s  = state_r;
    seq_pc_nxt_s = seq_pc_r;
    req_nxt_s    = imem_req;
    addr_nxt_s   = imem_addr;
    instr_nxt_s  = instr;
    pc_nxt_s     = pc_out;
    done_nxt_s   = 1'b0;
    err_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (PC_en) begin
          seq_pc_nxt_s = target_s + PC_STEP;
          if (misaligned_s) begin
            instr_nxt_s = IF_NOP;
            pc_nxt_s    = target_s;
            done_nxt_s  = 1'b1;
            err_nxt_s   = 1'b1;
          end else begin
            addr_nxt_s  = target_s;
            req_nxt_s   = 1'b1;
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (imem_gnt) begin
          req_nxt_s = 1'b0;
          if (imem_rvalid) begin
            instr_nxt_s = imem_rdata;
            pc_nxt_s    = imem_addr;
            done_nxt_s  = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_nxt_s = imem_rdata;
          pc_nxt_s    = imem_addr;
          done_nxt_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        req_nxt_s   = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      seq_pc_r   <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      instr      <= IF_NOP;
      pc_out     <= RESET_PC;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      seq_pc_r   <= seq_pc_nxt_s;
      imem_req   <= req_nxt_s;
      imem_addr  <= addr_nxt_s;
      instr      <= instr_nxt_s;
      pc_out     <= pc_nxt_s;
      fetch_done <= done_nxt_s;
      fetch_err  <= err_nxt_s;
    end
  end

  assign fetch_busy = (state_r != IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (default build or IF_ALIGN_CHECK_EN).
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_en, Jump_en, EXPC_en;
  logic [31:0] jump_target, ex_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        fetch_done, fetch_busy, fetch_err;

  int checks_r   = 0;
  int failures_r = 0;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PC_en       (PC_en),
    .Jump_en     (Jump_en),
    .EXPC_en     (EXPC_en),
    .jump_target (jump_target),
    .ex_target   (ex_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc_out      (pc_out),
    .fetch_done  (fetch_done),
    .fetch_busy  (fetch_busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      failures_r++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full zero-wait fetch with the given selects; checks address, instr and pc_out.
  task automatic zero_wait_fetch(input logic jmp, input logic ex, input logic [31:0] jt,
                                 input logic [31:0] et, input logic [31:0] exp_addr,
                                 input logic [31:0] data, input string tag);
    PC_en = 1'b1; Jump_en = jmp; EXPC_en = ex; jump_target = jt; ex_target = et;
    tick();
    PC_en = 1'b0; Jump_en = 1'b0; EXPC_en = 1'b0;
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = data;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    check({tag, "_instr"}, instr, data);
    check({tag, "_pc"}, pc_out, exp_addr);
    check({tag, "_done"}, {31'd0, fetch_done}, 32'd1);
    check({tag, "_busy"}, {31'd0, fetch_busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; PC_en = 1'b0; Jump_en = 1'b0; EXPC_en = 1'b0;
    jump_target = 32'h0; ex_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", pc_out, 32'h0);
    check("rst_flags", {29'd0, fetch_done, fetch_busy, fetch_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait fetch from reset PC, then one cycle later done drops.
    zero_wait_fetch(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 32'hAAAA_0001, "zw0");
    tick();
    check("zw0_done_pulse", {31'd0, fetch_done}, 32'd0);

    // rvalid while IDLE must not disturb instr.
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("idle_rvalid_instr", instr, 32'hAAAA_0001);
    check("idle_rvalid_done", {31'd0, fetch_done}, 32'd0);

    // Delayed grant: address held, PC_en pulses while busy are ignored.
    PC_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      PC_en = 1'b1; Jump_en = 1'b1; jump_target = 32'h0000_0500;
      check($sformatf("dly_addr%0d", i), imem_addr, 32'h0000_0004);
      check($sformatf("dly_req%0d", i), {31'd0, imem_req}, 32'd1);
      check($sformatf("dly_busy%0d", i), {31'd0, fetch_busy}, 32'd1);
      tick();
    end
    PC_en = 1'b0; Jump_en = 1'b0;
    check("dly_addr3", imem_addr, 32'h0000_0004);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("dly_wait_req", {31'd0, imem_req}, 32'd0);
    check("dly_wait_busy", {31'd0, fetch_busy}, 32'd1);
    tick();
    check("dly_wait2_done", {31'd0, fetch_done}, 32'd0);
    check("dly_wait2_busy", {31'd0, fetch_busy}, 32'd1);
    imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0002;
    tick();
    imem_rvalid = 1'b0;
    check("dly_instr", instr, 32'hBBBB_0002);
    check("dly_pc", pc_out, 32'h0000_0004);
    check("dly_done", {31'd0, fetch_done}, 32'd1);
    check("dly_busy_end", {31'd0, fetch_busy}, 32'd0);

    // Jump beats EX branch; back-to-back sequential fetch continues from jump+4.
    zero_wait_fetch(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 32'h0000_0100, 32'h1111_0003, "jmp");
    zero_wait_fetch(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0104, 32'h1111_0004, "jmp_seq");
    zero_wait_fetch(1'b0, 1'b1, 32'h0, 32'h0000_0200, 32'h0000_0200, 32'h1111_0005, "ex");

    // Sequential PC wrap at the top of the address space.
    zero_wait_fetch(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'h2222_0001, "wrap_j");
    zero_wait_fetch(1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h2222_0002, "wrap_top");
    zero_wait_fetch(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 32'h2222_0003, "wrap_zero");

    // Reset while waiting for rvalid; late rvalid afterwards is ignored.
    PC_en = 1'b1;
    tick();
    PC_en = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("mid_busy", {31'd0, fetch_busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_instr", instr, 32'h0000_0013);
    check("mid_rst_pc", pc_out, 32'h0);
    check("mid_rst_flags", {29'd0, fetch_done, fetch_busy, imem_req}, 32'd0);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0BAD;
    tick();
    imem_rvalid = 1'b0;
    check("late_rvalid_done", {31'd0, fetch_done}, 32'd0);
    check("late_rvalid_instr", instr, 32'h0000_0013);
    check("late_rvalid_busy", {31'd0, fetch_busy}, 32'd0);
    zero_wait_fetch(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 32'h3333_0001, "post_rst");

    // Misaligned jump target.
`ifdef IF_ALIGN_CHECK_EN
    PC_en = 1'b1; Jump_en = 1'b1; jump_target = 32'h0000_0102;
    tick();
    PC_en = 1'b0; Jump_en = 1'b0;
    check("mis_req", {31'd0, imem_req}, 32'd0);
    check("mis_err", {31'd0, fetch_err}, 32'd1);
    check("mis_done", {31'd0, fetch_done}, 32'd1);
    check("mis_instr", instr, 32'h0000_0013);
    check("mis_pc", pc_out, 32'h0000_0102);
    tick();
    check("mis_err_pulse", {31'd0, fetch_err}, 32'd0);
`else
    zero_wait_fetch(1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h0000_0100, 32'h4444_0001, "mis");
    check("mis_err", {31'd0, fetch_err}, 32'd0);
    zero_wait_fetch(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0104, 32'h4444_0002, "mis_seq");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
